camera_frame_packer: RTL and testbench

CAMERA_FRAME_PACKER -- requirements
Module: camera_frame_packer

---
 rtl/camera_frame_packer.sv | 161 ++++++++++++++++
 tb/tb_camera_frame_packer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : camera_frame_packer
// Brief    : Collects a raster-ordered stream of multi-channel INT8 pixels into
//            one packed frame register, hands it to a feature extractor with a
//            one-cycle start pulse and waits (with timeout) for completion.
// Revision : 1.0 - initial release
// ============================================================================
module camera_frame_packer #(
    parameter int H        = 16,
    parameter int W        = 8,
    parameter int C        = 3,
    parameter int WAIT_MAX = 32767
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [C*8-1:0]        pix_data,
    input  logic                  pix_sof,
    output logic [H*W*C*8-1:0]    image_out,
    output logic                  start,
    input  logic                  ext_done,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  sof_err,
    output logic                  timeout_err
);

    localparam int NPIX  = H * W;
    localparam int PIX_W = C * 8;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int TMR_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NPIX - 1);
    localparam logic [TMR_W-1:0] LAST_WAIT = TMR_W'(WAIT_MAX - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [15:0]      fcount_q, fcount_d;
    logic             sof_err_q, sof_err_d;
    logic             tmo_q, tmo_d;
    logic [PIX_W-1:0] pix_q [NPIX];

    logic             accept;
    logic             wr_en;
    logic [CNT_W-1:0] wr_idx;

    // Handshake and status are pure decodes of the state register.
    assign pix_ready   = (state_q == S_IDLE) || (state_q == S_FILL);
    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign start       = (state_q == S_ISSUE);
    assign accept      = pix_valid && pix_ready;
    assign frame_count = fcount_q;
    assign sof_err     = sof_err_q;
    assign timeout_err = tmo_q;

    // Next-state logic: frame fill sequencing, extractor handoff and wait timer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        fcount_d  = fcount_q;
        sof_err_d = 1'b0;
        tmo_d     = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = cnt_q;
        case (state_q)
            S_IDLE: begin
                // Beats without sof are dropped until a frame boundary shows up.
                if (accept && pix_sof) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = CNT_W'(1);
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (pix_sof) begin
                        // Restart wins even on the final index.
                        wr_idx    = '0;
                        cnt_d     = CNT_W'(1);
                        sof_err_d = 1'b1;
                    end else if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion has priority over a coincident timeout.
                if (ext_done) begin
                    fcount_d = fcount_q + 16'd1;
                    state_d  = S_IDLE;
                end else if (timer_q == LAST_WAIT) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timer_q   <= '0;
            fcount_q  <= '0;
            sof_err_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            fcount_q  <= fcount_d;
            sof_err_q <= sof_err_d;
            tmo_q     <= tmo_d;
        end
    end

    // Frame storage: only the addressed pixel changes, so the frame is stable outside writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPIX; p++) begin
                pix_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPIX; p++) begin
                if (wr_en && (wr_idx == CNT_W'(p))) begin
                    pix_q[p] <= pix_data;
                end
            end
        end
    end

    generate
        for (genvar gp = 0; gp < NPIX; gp++) begin : g_pack
            assign image_out[gp*PIX_W +: PIX_W] = pix_q[gp];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_camera_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_camera_frame_packer
// Brief    : Self-checking bench for camera_frame_packer: behavioural frame
//            model compared every cycle, directed scenarios, random traffic,
//            and a short-timeout second instance for the timeout boundary.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camera_frame_packer;

    localparam int H     = 16;
    localparam int W     = 8;
    localparam int C     = 3;
    localparam int NPIX  = H * W;
    localparam int PW    = C * 8;
    localparam int WMAX  = 32767;
    localparam int TWMAX = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_valid = 1'b0;
    logic pix_sof = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic ext_done = 1'b0;
    logic pix_ready, start, busy, sof_err, timeout_err;
    logic [NPIX*PW-1:0] image_out;
    logic [15:0] frame_count;

    // short-timeout instance shares the pixel stream, has its own reset/done
    logic t_rst = 1'b1;
    logic t_ext = 1'b0;
    logic t_ready, t_start, t_busy, t_sof_err, t_to;
    logic [NPIX*PW-1:0] t_img;
    logic [15:0] t_fc;

    always #5 clk = ~clk;

    camera_frame_packer #(.H(H), .W(W), .C(C), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_sof(pix_sof), .image_out(image_out),
        .start(start), .ext_done(ext_done), .busy(busy),
        .frame_count(frame_count), .sof_err(sof_err), .timeout_err(timeout_err)
    );

    camera_frame_packer #(.H(H), .W(W), .C(C), .WAIT_MAX(TWMAX)) u_to (
        .clk(clk), .rst(t_rst), .pix_valid(pix_valid), .pix_ready(t_ready),
        .pix_data(pix_data), .pix_sof(pix_sof), .image_out(t_img),
        .start(t_start), .ext_done(t_ext), .busy(t_busy),
        .frame_count(t_fc), .sof_err(t_sof_err), .timeout_err(t_to)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_soferr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase of the frame life cycle: collecting, handing off, waiting
    localparam int PH_IDLE = 0, PH_FILL = 1, PH_ISSUE = 2, PH_WAIT = 3;
    int            m_phase;
    int            m_got;        // pixels of the current frame received so far
    int            m_waited;     // cycles already spent waiting for the extractor
    logic [PW-1:0] m_pix [NPIX];
    int            m_fc;
    bit            m_sof_err, m_to;

    task automatic model_reset();
        m_phase = PH_IDLE; m_got = 0; m_waited = 0; m_fc = 0;
        m_sof_err = 0; m_to = 0;
        for (int p = 0; p < NPIX; p++) m_pix[p] = '0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            bit take;
            take = pix_valid && (m_phase == PH_IDLE || m_phase == PH_FILL);
            m_sof_err = 0;
            m_to = 0;
            if (m_phase == PH_WAIT) begin
                m_waited++;
                if (ext_done) begin
                    m_phase = PH_IDLE;
                    m_fc = (m_fc + 1) % 65536;
                end else if (m_waited >= WMAX) begin
                    m_phase = PH_IDLE;
                    m_to = 1;
                end
            end else if (m_phase == PH_ISSUE) begin
                m_phase = PH_WAIT;
                m_waited = 0;
            end else if (take && pix_sof) begin
                if (m_phase == PH_FILL) m_sof_err = 1;
                m_pix[0] = pix_data;
                m_got = 1;
                m_phase = PH_FILL;
            end else if (take && m_phase == PH_FILL) begin
                m_pix[m_got] = pix_data;
                m_got++;
                if (m_got == NPIX) m_phase = PH_ISSUE;
            end
        end
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int bad_p;
        if (rst) model_reset();
        chk("pix_ready", pix_ready, (m_phase == PH_IDLE || m_phase == PH_FILL));
        chk("busy", busy, (m_phase == PH_ISSUE || m_phase == PH_WAIT));
        chk("start", start, (m_phase == PH_ISSUE));
        chk("sof_err", sof_err, m_sof_err);
        chk("timeout_err", timeout_err, m_to);
        chk("frame_count", frame_count, 64'(m_fc));
        bad_p = -1;
        for (int p = 0; p < NPIX; p++)
            if (bad_p < 0 && image_out[p*PW +: PW] !== m_pix[p]) bad_p = p;
        n_cmp++;
        if (bad_p >= 0) begin
            n_bad++;
            $display("FAIL image pixel %0d: got %0h expected %0h",
                     bad_p, image_out[bad_p*PW +: PW], m_pix[bad_p]);
        end
        if (start === 1'b1) n_start++;
        if (sof_err === 1'b1) n_soferr++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pat(input int p, input int s);
        return {8'(p + 2 + s), 8'(p + 1 + s), 8'(p + s)};
    endfunction

    task automatic beats(input int first, input int n, input int seed, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_sof   = sof_first && (i == 0);
            pix_data  = pat(first + i, seed);
            tick();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic done_after(input int dly);
        for (int i = 0; i < dly; i++) tick();
        ext_done = 1'b1;
        tick();
        ext_done = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s0, e0, n;
        repeat (3) tick();
        chk("rst_ready", pix_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_img", image_out[63:0], 0);
        rst = 1'b0;
        tick();

        // full frame, pixel p = {p+2,p+1,p}
        s0 = n_start;
        beats(0, NPIX, 0, 1'b1);
        chk("f1_start", start, 1);
        chk("f1_busy", busy, 1);
        chk("f1_prior_starts", 64'(n_start - s0), 0);
        chk("f1_b0", image_out[7:0], 8'h00);
        chk("f1_b1", image_out[15:8], 8'h01);
        chk("f1_btop", image_out[3071:3064], 8'h81);

        // long wait with a valid sof beat held: nothing may be accepted
        pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 24'hABCDEF;
        for (int i = 0; i < 18499; i++) tick();
        ext_done = 1'b1;
        tick();
        ext_done = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        chk("f1_fc", frame_count, 1);
        chk("f1_ready", pix_ready, 1);
        chk("f1_hold", image_out[7:0], 8'h00);

        // 5 orphan beats, then a full frame
        beats(200, 5, 0, 1'b0);
        beats(0, NPIX, 40, 1'b1);
        chk("f2_b0", image_out[23:0], 24'h2A2928);
        done_after(7);

        // sof restart at beat 60
        s0 = n_start; e0 = n_soferr;
        beats(0, 60, 3, 1'b1);
        beats(0, NPIX, 90, 1'b1);
        chk("f3_start", start, 1);
        chk("f3_b0", image_out[23:0], 24'h5C5B5A);
        tick();
        chk("f3_starts", 64'(n_start - s0), 1);
        chk("f3_soferr", 64'(n_soferr - e0), 1);
        done_after(3);

        // short-timeout instance: timeout at wait cycle 100
        t_rst = 1'b0;
        tick();
        beats(0, NPIX, 5, 1'b1);
        chk("t_start", t_start, 1);
        n = 0;
        while (t_to !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("t_timeout_cycle", 64'(n), 101);
        chk("t_ready", t_ready, 1);
        chk("t_busy", t_busy, 0);
        chk("t_fc", t_fc, 0);
        tick();
        chk("t_to_pulse", t_to, 0);
        done_after(2);

        // done on the very last wait cycle beats the timeout
        beats(0, NPIX, 6, 1'b1);
        for (int i = 0; i < 100; i++) tick();
        chk("t_last_busy", t_busy, 1);
        t_ext = 1'b1;
        tick();
        t_ext = 1'b0;
        chk("t_edge_fc", t_fc, 1);
        chk("t_edge_to", t_to, 0);
        chk("t_edge_busy", t_busy, 0);
        t_rst = 1'b1;
        done_after(4);

        // reset in the middle of a fill
        s0 = n_start;
        beats(0, 50, 11, 1'b1);
        pix_valid = 1'b1; pix_data = pat(50, 11);
        rst = 1'b1;
        tick();
        pix_valid = 1'b0;
        chk("r_img_lo", image_out[63:0], 0);
        chk("r_fc", frame_count, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("r_no_start", 64'(n_start - s0), 0);
        beats(0, NPIX, 20, 1'b1);
        chk("r_b0", image_out[23:0], 24'h161514);
        chk("r_btop", image_out[3071:3048], {8'(127+22), 8'(127+21), 8'(127+20)});
        done_after(1);
        chk("r_fc1", frame_count, 1);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            pix_valid = ($urandom_range(9) < 7);
            pix_sof   = (m_phase == PH_IDLE) ? ($urandom_range(3) == 0)
                                             : ($urandom_range(299) == 0);
            pix_data  = 24'($urandom);
            ext_done  = ($urandom_range(39) == 0);
            tick();
        end
        pix_valid = 1'b0; ext_done = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
